// File: rtl/tlu_emulator_if.sv
// Bundle of control, status and TLU-line signals for the TLU emulator.
// master: the emulator itself. slave: whatever drives its controls and plays the DUT side.
interface tlu_emulator_if #(
    parameter int TRIGGER_NUMBER_BITS = 15
);
    logic [1:0]                     MODE;
    logic                           TRIGGER_REQ;
    logic                           RESET_REQ;
    logic [7:0]                     TIMEOUT_CYCLES;
    logic                           TLU_BUSY;
    logic                           TLU_CLOCK;
    logic                           TLU_TRIGGER;
    logic                           TLU_RESET;
    logic                           READY;
    logic                           TRIGGER_ACCEPTED;
    logic [TRIGGER_NUMBER_BITS-1:0] TRIGGER_COUNT;
    logic                           TIMEOUT_ERROR;

    modport master (
        input  MODE, TRIGGER_REQ, RESET_REQ, TIMEOUT_CYCLES, TLU_BUSY, TLU_CLOCK,
        output TLU_TRIGGER, TLU_RESET, READY, TRIGGER_ACCEPTED, TRIGGER_COUNT, TIMEOUT_ERROR
    );

    modport slave (
        output MODE, TRIGGER_REQ, RESET_REQ, TIMEOUT_CYCLES, TLU_BUSY, TLU_CLOCK,
        input  TLU_TRIGGER, TLU_RESET, READY, TRIGGER_ACCEPTED, TRIGGER_COUNT, TIMEOUT_ERROR
    );
endinterface

// File: rtl/tlu_emulator.sv
// TLU emulator: plays the TLU end of the EUDET trigger/busy/clock handshake.
// Issues triggers and reset pulses and serialises the trigger number LSB first
// on TLU_CLOCK rising edges in trigger-data mode. All outputs are registered.
module tlu_emulator #(
    parameter int TRIGGER_NUMBER_BITS  = 15,
    parameter int TRIGGER_PULSE_CYCLES = 4,
    parameter int RESET_PULSE_CYCLES   = 4,
    parameter int DEAD_TIME_CYCLES     = 8
) (
    input  logic           BUS_CLK,
    input  logic           BUS_RST,
    tlu_emulator_if.master bus
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIGGER_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME_CYCLES - 1);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_NOHS   = 2'b01;
    localparam logic [1:0] MODE_SIMPLE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_PULSE,
        S_TRIG,
        S_WAIT_CLK_LOW,
        S_SHIFT,
        S_WAIT_BUSY_LOW,
        S_DEAD
    } state_t;

    state_t                         state_q, state_d;
    logic [1:0]                     mode_q, mode_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [TRIGGER_NUMBER_BITS-1:0] shift_q, shift_d;
    logic [TRIGGER_NUMBER_BITS-1:0] count_q, count_d;
    logic                           trigger_q, trigger_d;
    logic                           tluReset_q, tluReset_d;
    logic                           ready_q, ready_d;
    logic                           accepted_q, accepted_d;
    logic                           error_q, error_d;

    logic [2:0]       busySync_q;
    logic [2:0]       clkSync_q;
    logic             clkPrev_q;
    logic             busyS;
    logic             clkS;
    logic             clkRise;
    logic [CNT_W-1:0] timeoutLast;

    assign busyS       = busySync_q[2];
    assign clkS        = clkSync_q[2];
    assign clkRise     = clkS & ~clkPrev_q;
    assign timeoutLast = CNT_W'(bus.TIMEOUT_CYCLES) - CNT_W'(1);

    // Three-flop synchronisers for the DUT's asynchronous BUSY and CLOCK, plus the edge-detect flop.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            busySync_q <= '0;
            clkSync_q  <= '0;
            clkPrev_q  <= 1'b0;
        end else begin
            busySync_q <= {busySync_q[1:0], bus.TLU_BUSY};
            clkSync_q  <= {clkSync_q[1:0], bus.TLU_CLOCK};
            clkPrev_q  <= clkS;
        end
    end

    // State, counters and registered outputs; reset abandons any trigger in flight.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_OFF;
            cnt_q      <= '0;
            shift_q    <= '0;
            count_q    <= '0;
            trigger_q  <= 1'b0;
            tluReset_q <= 1'b0;
            ready_q    <= 1'b0;
            accepted_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            trigger_q  <= trigger_d;
            tluReset_q <= tluReset_d;
            ready_q    <= ready_d;
            accepted_q <= accepted_d;
            error_q    <= error_d;
        end
    end

    // Next-state and next-output logic; the line values computed here appear one cycle later.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        count_d    = count_q;
        trigger_d  = 1'b0;
        tluReset_d = 1'b0;
        accepted_d = 1'b0;
        error_d    = error_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.MODE != MODE_OFF) begin
                    if (bus.RESET_REQ) begin
                        state_d    = S_RST_PULSE;
                        tluReset_d = 1'b1;
                        count_d    = '0;
                    end else if (bus.TRIGGER_REQ) begin
                        state_d    = S_TRIG;
                        trigger_d  = 1'b1;
                        accepted_d = 1'b1;
                        mode_d     = bus.MODE;
                        shift_d    = count_q;
                        count_d    = count_q + TRIGGER_NUMBER_BITS'(1);
                    end
                end
            end

            S_RST_PULSE: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_DEAD;
                    cnt_d   = '0;
                end else begin
                    tluReset_d = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end

            S_TRIG: begin
                if (mode_q == MODE_NOHS) begin
                    if (cnt_q == TRIG_LAST) begin
                        state_d = S_DEAD;
                        cnt_d   = '0;
                    end else begin
                        trigger_d = 1'b1;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end else if (busyS) begin
                    state_d = (mode_q == MODE_SIMPLE) ? S_WAIT_BUSY_LOW : S_WAIT_CLK_LOW;
                end else if ((bus.TIMEOUT_CYCLES != 8'd0) && (cnt_q == timeoutLast)) begin
                    error_d = 1'b1;
                    state_d = S_DEAD;
                    cnt_d   = '0;
                end else begin
                    trigger_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_CLK_LOW: begin
                if (!clkS) begin
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (!busyS) begin
                    state_d = S_DEAD;
                    cnt_d   = '0;
                end else if (clkRise) begin
                    trigger_d = shift_q[0];
                    shift_d   = shift_q >> 1;
                end else begin
                    trigger_d = trigger_q;
                end
            end

            S_WAIT_BUSY_LOW: begin
                if (!busyS) begin
                    state_d = S_DEAD;
                    cnt_d   = '0;
                end
            end

            S_DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE) && (bus.MODE != MODE_OFF);
    end

    assign bus.TLU_TRIGGER      = trigger_q;
    assign bus.TLU_RESET        = tluReset_q;
    assign bus.READY            = ready_q;
    assign bus.TRIGGER_ACCEPTED = accepted_q;
    assign bus.TRIGGER_COUNT    = count_q;
    assign bus.TIMEOUT_ERROR    = error_q;

endmodule

// File: tb/tb_tlu_emulator.sv
// Randomised bench for the TLU emulator. A behavioural model tracks the trigger
// number and sticky error; each handshake mode is exercised with a small DUT-side model.
module tb_tlu_emulator;

    localparam int NB       = 8;
    localparam int PULSE    = 4;
    localparam int RSTP     = 4;
    localparam int DEADT    = 8;
    // Three synchroniser stages plus the registered output line.
    localparam int BUSY_LAT = 4;

    logic BUS_CLK = 1'b0;
    logic BUS_RST;

    int vectorCount = 0;
    int errorCount  = 0;
    int expCount    = 0;
    int expError    = 0;

    tlu_emulator_if #(.TRIGGER_NUMBER_BITS(NB)) bus ();

    tlu_emulator #(
        .TRIGGER_NUMBER_BITS (NB),
        .TRIGGER_PULSE_CYCLES(PULSE),
        .RESET_PULSE_CYCLES  (RSTP),
        .DEAD_TIME_CYCLES    (DEADT)
    ) dut (
        .BUS_CLK(BUS_CLK),
        .BUS_RST(BUS_RST),
        .bus    (bus)
    );

    // Free-running bus clock.
    always #5 BUS_CLK = ~BUS_CLK;

    // Guard against a hung handshake.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic trigReq, input logic rstReq);
        bus.MODE        = mode;
        bus.TRIGGER_REQ = trigReq;
        bus.RESET_REQ   = rstReq;
        tick();
        bus.TRIGGER_REQ = 1'b0;
        bus.RESET_REQ   = 1'b0;
    endtask

    task automatic waitReady(input string tag, output int cycles);
        cycles = 0;
        while (!bus.READY && cycles < 500) begin
            tick();
            cycles++;
        end
        checkOutput(tag, 32'(bus.READY), 1);
    endtask

    task automatic issueTrigger(input logic [1:0] mode, output int number);
        int c;
        bus.MODE = mode;
        waitReady("readyBefore", c);
        number = expCount;
        applyStimulus(mode, 1'b1, 1'b0);
        expCount = (expCount + 1) % (1 << NB);
        checkOutput("accepted", 32'(bus.TRIGGER_ACCEPTED), 1);
        checkOutput("countInc", 32'(bus.TRIGGER_COUNT), expCount);
        checkOutput("trigRise", 32'(bus.TLU_TRIGGER), 1);
        checkOutput("readyLow", 32'(bus.READY), 0);
    endtask

    task automatic doMode01();
        int num, high, acc, lat;
        issueTrigger(2'b01, num);
        high = 0;
        acc  = 0;
        while (bus.TLU_TRIGGER && high < 100) begin
            high++;
            acc += 32'(bus.TRIGGER_ACCEPTED);
            bus.TLU_BUSY = 1'($urandom_range(0, 1));
            tick();
        end
        bus.TLU_BUSY = 1'b0;
        checkOutput("m01High", high, PULSE);
        checkOutput("m01AccOnce", acc, 1);
        waitReady("m01Ready", lat);
        checkOutput("m01ReadyLat", high + lat, PULSE + DEADT);
        checkOutput("m01Err", 32'(bus.TIMEOUT_ERROR), expError);
    endtask

    task automatic doMode10(input int delay, input int hold, input bit switchMode);
        int num, high, lat, bad;
        issueTrigger(2'b10, num);
        high = 0;
        for (int i = 0; i < delay; i++) begin
            tick();
            if (switchMode && i == 0) bus.MODE = 2'b01;
            high += 32'(bus.TLU_TRIGGER);
        end
        checkOutput("m10HoldHigh", high, delay);
        bus.TLU_BUSY = 1'b1;
        lat = 0;
        while (bus.TLU_TRIGGER && lat < 100) begin
            tick();
            lat++;
        end
        checkOutput("m10DropLat", lat, BUSY_LAT);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            bad += 32'(bus.TLU_TRIGGER | bus.READY);
        end
        checkOutput("m10LowWhileBusy", bad, 0);
        bus.TLU_BUSY = 1'b0;
        waitReady("m10Ready", lat);
        checkOutput("m10ReadyLat", lat, BUSY_LAT + DEADT);
        bus.MODE = 2'b10;
    endtask

    task automatic doMode11(input int delay);
        int num, lat, acc, value, extra;
        issueTrigger(2'b11, num);
        repeat (delay) tick();
        bus.TLU_BUSY = 1'b1;
        lat = 0;
        while (bus.TLU_TRIGGER && lat < 100) begin
            tick();
            lat++;
        end
        checkOutput("m11DropLat", lat, BUSY_LAT);
        repeat (6) tick();
        checkOutput("m11LineLow", 32'(bus.TLU_TRIGGER), 0);
        value = 0;
        extra = 0;
        acc   = 0;
        for (int k = 0; k <= NB; k++) begin
            bus.TLU_CLOCK = 1'b1;
            if (k == 1) bus.TRIGGER_REQ = 1'b1;
            repeat (6) begin
                tick();
                acc += 32'(bus.TRIGGER_ACCEPTED);
            end
            if (k < NB) value = value | (32'(bus.TLU_TRIGGER) << k);
            else        extra = 32'(bus.TLU_TRIGGER);
            bus.TLU_CLOCK = 1'b0;
            repeat (6) begin
                tick();
                acc += 32'(bus.TRIGGER_ACCEPTED);
            end
        end
        bus.TRIGGER_REQ = 1'b0;
        checkOutput("m11Number", value, num);
        checkOutput("m11ExtraBit", extra, 0);
        checkOutput("m11NoAccept", acc, 0);
        checkOutput("m11CountHeld", 32'(bus.TRIGGER_COUNT), expCount);
        bus.TLU_BUSY = 1'b0;
        waitReady("m11Ready", lat);
        checkOutput("m11ReadyLat", lat, BUSY_LAT + DEADT);
    endtask

    task automatic doTimeout(input int limit);
        int num, high, lat;
        bus.TIMEOUT_CYCLES = 8'(limit);
        issueTrigger(2'b11, num);
        high = 0;
        while (bus.TLU_TRIGGER && high < 300) begin
            high++;
            tick();
        end
        checkOutput("toHigh", high, limit);
        expError = 1;
        checkOutput("toError", 32'(bus.TIMEOUT_ERROR), expError);
        waitReady("toReady", lat);
        checkOutput("toReadyLat", lat, DEADT);
        bus.TIMEOUT_CYCLES = 8'd0;
    endtask

    initial begin
        int num, lat, high, trig;

        BUS_RST            = 1'b1;
        bus.MODE           = 2'b01;
        bus.TRIGGER_REQ    = 1'b0;
        bus.RESET_REQ      = 1'b0;
        bus.TIMEOUT_CYCLES = 8'd0;
        bus.TLU_BUSY       = 1'b0;
        bus.TLU_CLOCK      = 1'b0;
        repeat (3) tick();
        checkOutput("rstTrig", 32'(bus.TLU_TRIGGER), 0);
        checkOutput("rstReset", 32'(bus.TLU_RESET), 0);
        checkOutput("rstReady", 32'(bus.READY), 0);
        checkOutput("rstAcc", 32'(bus.TRIGGER_ACCEPTED), 0);
        checkOutput("rstCount", 32'(bus.TRIGGER_COUNT), 0);
        checkOutput("rstErr", 32'(bus.TIMEOUT_ERROR), 0);
        BUS_RST = 1'b0;
        tick();
        checkOutput("readyAfterRst", 32'(bus.READY), 1);

        // Disabled mode ignores every request.
        bus.MODE = 2'b00;
        repeat (2) tick();
        checkOutput("offReady", 32'(bus.READY), 0);
        applyStimulus(2'b00, 1'b1, 1'b0);
        checkOutput("offAcc", 32'(bus.TRIGGER_ACCEPTED), 0);
        tick();
        checkOutput("offTrig", 32'(bus.TLU_TRIGGER), 0);
        checkOutput("offCount", 32'(bus.TRIGGER_COUNT), expCount);
        applyStimulus(2'b00, 1'b0, 1'b1);
        checkOutput("offReset", 32'(bus.TLU_RESET), 0);

        for (int t = 0; t < 3; t++) doMode01();

        for (int t = 0; t < 4; t++)
            doMode10(int'($urandom_range(5, 20)), int'($urandom_range(10, 25)), t == 1);

        for (int t = 0; t < 4; t++) begin
            repeat ($urandom_range(0, 5)) doMode01();
            doMode11(int'($urandom_range(1, 10)));
        end

        doTimeout(50);
        doMode01();
        doTimeout(int'($urandom_range(10, 40)));
        doMode11(3);

        // Reset request wins over a same-cycle trigger request.
        bus.MODE = 2'b01;
        waitReady("rrReadyBefore", lat);
        applyStimulus(2'b01, 1'b1, 1'b1);
        expCount = 0;
        checkOutput("rrAcc", 32'(bus.TRIGGER_ACCEPTED), 0);
        checkOutput("rrCount", 32'(bus.TRIGGER_COUNT), 0);
        high = 0;
        trig = 0;
        while (bus.TLU_RESET && high < 100) begin
            high++;
            trig += 32'(bus.TLU_TRIGGER);
            tick();
        end
        checkOutput("rrPulse", high, RSTP);
        checkOutput("rrNoTrig", trig, 0);
        waitReady("rrReady", lat);
        checkOutput("rrReadyLat", lat, DEADT);

        // Bus reset in the middle of a shift-out.
        doMode01();
        issueTrigger(2'b11, num);
        repeat (3) tick();
        bus.TLU_BUSY = 1'b1;
        repeat (10) tick();
        bus.TLU_CLOCK = 1'b1;
        repeat (6) tick();
        checkOutput("midBit", 32'(bus.TLU_TRIGGER), 1);
        BUS_RST = 1'b1;
        tick();
        expCount = 0;
        expError = 0;
        checkOutput("midTrig", 32'(bus.TLU_TRIGGER), 0);
        checkOutput("midCount", 32'(bus.TRIGGER_COUNT), 0);
        checkOutput("midErr", 32'(bus.TIMEOUT_ERROR), 0);
        checkOutput("midReady", 32'(bus.READY), 0);
        BUS_RST       = 1'b0;
        bus.TLU_BUSY  = 1'b0;
        bus.TLU_CLOCK = 1'b0;
        tick();
        checkOutput("midIdle", 32'(bus.READY), 1);

        // Counter wrap: all-ones number is shifted out, then the count returns to zero.
        for (int t = 0; t < (1 << NB) - 1; t++) doMode01();
        checkOutput("wrapMax", 32'(bus.TRIGGER_COUNT), (1 << NB) - 1);
        doMode11(4);
        checkOutput("wrapZero", 32'(bus.TRIGGER_COUNT), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule

// File: doc/tlu_emulator.md
Name: tlu_emulator

Overview:
- Plays the TLU end of the EUDET TLU trigger/handshake protocol for bench and loopback setups without a real TLU.
- Issues TLU_TRIGGER and TLU_RESET to a DUT-side TLU controller and watches its TLU_BUSY and TLU_CLOCK.
- In data-handshake mode, serialises a running trigger number onto TLU_TRIGGER, one bit per TLU_CLOCK edge.
- Sits on BUS_CLK next to the TLU controller, or drives it through the RJ45/LEMO pins.

Parameters:
- TRIGGER_NUMBER_BITS, 15: width of the trigger number shifted out and of the internal counter.
- TRIGGER_PULSE_CYCLES, 4: TLU_TRIGGER high time in no-handshake mode.
- RESET_PULSE_CYCLES, 4: TLU_RESET high time.
- DEAD_TIME_CYCLES, 8: idle gap after each completed or aborted trigger before READY returns.

Ports:
- BUS_CLK  in  1  sole clock.
- BUS_RST  in  1  reset, synchronous, active-high.
- MODE  in  2  00 disabled, 01 no handshake, 10 simple handshake, 11 trigger data handshake.
- TRIGGER_REQ  in  1  request one trigger; sampled in IDLE only.
- RESET_REQ  in  1  request a TLU reset pulse; sampled in IDLE only.
- TIMEOUT_CYCLES  in  8  BUSY-wait limit in cycles; 0 = no timeout.
- TLU_BUSY  in  1  from DUT, asynchronous.
- TLU_CLOCK  in  1  from DUT, asynchronous.
- TLU_TRIGGER  out  1  trigger / serial data line.
- TLU_RESET  out  1  TLU reset line.
- READY  out  1  high in IDLE with MODE != 00.
- TRIGGER_ACCEPTED  out  1  one-cycle pulse when a trigger is issued.
- TRIGGER_COUNT  out  TRIGGER_NUMBER_BITS  number the next trigger will carry.
- TIMEOUT_ERROR  out  1  sticky; cleared only by BUS_RST.

Behaviour:
- Reset: on BUS_RST all outputs are 0, TRIGGER_COUNT is 0, FSM goes to IDLE. This applies mid-operation too, and the in-flight trigger is abandoned.
- Input sync: TLU_BUSY and TLU_CLOCK each pass a 3-stage synchroniser, giving BUSY_S and CLK_S. Every reference below is to the synced value. The CLK_S rising edge is detected with one extra flop.
- IDLE:
  - MODE==00: outputs low, all requests ignored.
  - RESET_REQ has priority over TRIGGER_REQ in the same cycle; the trigger is dropped with no ACCEPTED pulse.
  - On RESET_REQ: go to RST_PULSE and zero TRIGGER_COUNT.
  - On TRIGGER_REQ: pulse TRIGGER_ACCEPTED, latch MODE into the active mode and TRIGGER_COUNT into the shift register, increment TRIGGER_COUNT (wraps at 2^TRIGGER_NUMBER_BITS to 0), and go to TRIG.
  - Requests outside IDLE are ignored.
  - A MODE change mid-trigger has no effect until the next IDLE.
- RST_PULSE: TLU_RESET=1 for RESET_PULSE_CYCLES cycles, then DEAD.
- TRIG: TLU_TRIGGER rises the cycle after acceptance.
  - Mode 01: hold high TRIGGER_PULSE_CYCLES cycles, then DEAD. BUSY is ignored.
  - Modes 10/11: hold high until BUSY_S=1.
    - Mode 10 then goes to WAIT_BUSY_LOW.
    - Mode 11 then goes to WAIT_CLK_LOW.
  - TLU_TRIGGER drops in the cycle the state leaves TRIG.
- Timeout (modes 10/11, TRIG state):
  - A cycle counter starts at TRIG entry.
  - If TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES with BUSY_S still 0: set TIMEOUT_ERROR, drop TLU_TRIGGER, go to DEAD.
  - The number stays consumed.
- WAIT_CLK_LOW: TLU_TRIGGER=0. Wait for CLK_S=0 (DUT may hold the clock high while vetoing), then SHIFT with bit index 0.
- SHIFT:
  - On each CLK_S rising edge, drive TLU_TRIGGER = shift[index] (LSB first) in the next cycle and increment the index.
  - After TRIGGER_NUMBER_BITS bits, further edges drive 0.
  - BUSY_S=0 at any point goes to DEAD with TLU_TRIGGER=0. This covers short reads and extra clocks.
- WAIT_BUSY_LOW: TLU_TRIGGER=0; on BUSY_S=0 go to DEAD.
- DEAD: all lines low for DEAD_TIME_CYCLES cycles, then IDLE.
- READY is registered, so it is 0 from the cycle after acceptance through DEAD.

Test Plan:
- Mode 01, TRIGGER_PULSE_CYCLES=4, one TRIGGER_REQ -> TLU_TRIGGER high exactly 4 cycles; TRIGGER_COUNT 0->1; READY back after 4+8 cycles; BUSY ignored.
- Mode 10, BUSY model asserts 5 cycles after trigger and releases 20 cycles later -> TLU_TRIGGER drops ≤1 cycle after BUSY_S high; READY returns 8 cycles after BUSY_S low.
- Mode 11, TRIGGER_COUNT preset to 0x2A5B via BUS_RST then 0x2A5B requests, DUT model clocks 15 edges at divisor 12 -> sampled bits LSB first reconstruct 0x2A5B; a 16th edge samples 0.
- Mode 11, BUSY never asserted, TIMEOUT_CYCLES=50 -> TLU_TRIGGER drops at cycle 50; TIMEOUT_ERROR=1 and stays 1; next trigger carries an incremented number.
- RESET_REQ and TRIGGER_REQ in the same IDLE cycle -> TLU_RESET pulse 4 cycles, no TLU_TRIGGER, no ACCEPTED, TRIGGER_COUNT=0; TRIGGER_REQ during SHIFT ignored.
- BUS_RST asserted mid-SHIFT -> next cycle TLU_TRIGGER=0, TRIGGER_COUNT=0, TIMEOUT_ERROR=0, state IDLE; counter at 0x7FFF wraps to 0 after one trigger.
